// File: rtl/sha256_msg_sequencer.sv
// rtl/sha256_msg_sequencer.sv - SHA-256 front end: byte intake, FIPS 180-4 padding, block issue to core
// Bytes fill a 512-bit block register MSB-first; the FSM pads, appends the bit length and hands blocks to the core.
module sha256_msg_sequencer #(
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 127
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] digest_out,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy,
    output logic         err,
    output logic         core_start,
    output logic         core_first_run,
    output logic [511:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_ready
);

    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_PAD80, S_PADZ, S_LEN, S_ISSUE, S_WCLR, S_WRDY, S_OUT
    } state_t;

    state_t           state;
    state_t           cont;
    logic [6:0]       idx;
    logic [LEN_W-1:0] bytecnt;
    logic             first_blk;
    logic [TW-1:0]    tcnt;
    logic [8:0]       hi;
    logic             accept;

    // Top bit of byte slot idx within the block: 511 - 8*idx.
    assign hi     = ~{idx[5:0], 3'b000};
    assign accept = in_valid & in_ready;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cont           <= S_IDLE;
            idx            <= '0;
            bytecnt        <= '0;
            first_blk      <= 1'b1;
            tcnt           <= '0;
            in_ready       <= 1'b0;
            digest_out     <= '0;
            digest_valid   <= 1'b0;
            err            <= 1'b0;
            core_start     <= 1'b0;
            core_first_run <= 1'b0;
            core_block     <= '0;
        end else begin
            core_start     <= 1'b0;
            core_first_run <= 1'b0;
            case (state)
                S_IDLE, S_FILL: begin
                    if (accept) begin
                        core_block[hi -: 8] <= in_data;
                        idx     <= idx + 7'd1;
                        bytecnt <= bytecnt + LEN_W'(1);
                        if (idx == 7'd63) begin
                            // Block full: issue it now, padding (if last) continues in a fresh block.
                            in_ready       <= 1'b0;
                            state          <= S_ISSUE;
                            cont           <= in_last ? S_PAD80 : S_FILL;
                            core_start     <= 1'b1;
                            core_first_run <= first_blk;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= S_PAD80;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_FILL;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_PAD80: begin
                    core_block[hi -: 8] <= 8'h80;
                    idx   <= idx + 7'd1;
                    state <= S_PADZ;
                end
                S_PADZ: begin
                    if (idx == 7'd56) begin
                        state <= S_LEN;
                    end else if (idx == 7'd64) begin
                        // No room for the length field: flush and zero-fill a further block.
                        state          <= S_ISSUE;
                        cont           <= S_PADZ;
                        core_start     <= 1'b1;
                        core_first_run <= first_blk;
                    end else begin
                        core_block[hi -: 8] <= 8'h00;
                        idx <= idx + 7'd1;
                    end
                end
                S_LEN: begin
                    core_block[63:0] <= {{(61-LEN_W){1'b0}}, bytecnt, 3'b000};
                    state            <= S_ISSUE;
                    cont             <= S_OUT;
                    core_start       <= 1'b1;
                    core_first_run   <= first_blk;
                end
                S_ISSUE: begin
                    state <= S_WCLR;
                end
                S_WCLR: begin
                    tcnt  <= '0;
                    state <= S_WRDY;
                end
                S_WRDY: begin
                    if (core_ready) begin
                        first_blk  <= 1'b0;
                        idx        <= '0;
                        core_block <= '0;
                        state      <= cont;
                        if (cont == S_OUT) begin
                            digest_out   <= core_hash;
                            digest_valid <= 1'b1;
                        end
                        if (cont == S_FILL) in_ready <= 1'b1;
                    end else if (tcnt >= TW'(TIMEOUT)) begin
                        err        <= 1'b1;
                        state      <= S_IDLE;
                        in_ready   <= 1'b1;
                        first_blk  <= 1'b1;
                        idx        <= '0;
                        bytecnt    <= '0;
                        core_block <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_OUT: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        bytecnt      <= '0;
                        first_blk    <= 1'b1;
                        in_ready     <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb/tb_sha256_msg_sequencer.sv - bench for sha256_msg_sequencer with a behavioural SHA-256 core and padding model
module tb_sha256_msg_sequencer;

    localparam int TIMEOUT = 127;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic [255:0] digest_out;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;
    logic         err;
    logic         core_start;
    logic         core_first_run;
    logic [511:0] core_block;
    logic [255:0] core_hash;
    logic         core_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg [$];
    logic [511:0] got_blk [$];
    logic         got_fr [$];
    logic [511:0] exp_blk [$];
    logic         stub;
    int           fixed_lat;

    sha256_msg_sequencer #(.LEN_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .digest_out(digest_out), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .busy(busy), .err(err), .core_start(core_start),
        .core_first_run(core_first_run), .core_block(core_block), .core_hash(core_hash),
        .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core stand-in: chains the real compression function, random latency, optional stuck-not-ready stub.
    initial begin
        logic [255:0] cur_h;
        int cnt;
        cur_h = '0;
        cnt = 0;
        core_ready = 1'b1;
        core_hash = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_ready = 1'b1;
                cnt = 0;
            end else if (stub) begin
                core_ready = 1'b0;
            end else if (core_start) begin
                got_blk.push_back(core_block);
                got_fr.push_back(core_first_run);
                cur_h = compress(core_first_run ? IV : cur_h, core_block);
                core_ready = 1'b0;
                cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_hash = cur_h;
                    core_ready = 1'b1;
                end
            end
        end
    end

    task automatic build_expected(output int nblk, output logic [255:0] dig);
        logic [7:0]   p [$];
        logic [63:0]  len64;
        logic [511:0] blk;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len64 = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(len64[8*i +: 8]);
        exp_blk.delete();
        dig = IV;
        nblk = p.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*bi+i];
            exp_blk.push_back(blk);
            dig = compress(dig, blk);
        end
    endtask

    task automatic send_msg(input bit gaps, input bit mark_last);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < msg.size() && guard < 20000) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = msg[i];
                in_last  = mark_last && (i == msg.size() - 1);
                if (in_ready) i++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_bound", 512'(i), 512'(msg.size()));
    endtask

    task automatic run_msg(input string tag, input bit gaps, input int hold, output logic [255:0] dig_o);
        int nblk;
        int waitc;
        logic [255:0] exp_dig;
        build_expected(nblk, exp_dig);
        got_blk.delete();
        got_fr.delete();
        send_msg(gaps, 1'b1);
        waitc = 0;
        while (!digest_valid && waitc < 4000) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_dvalid"}, 512'(digest_valid), 512'(1));
        dig_o = digest_out;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_dig"}, 512'(digest_out), 512'(dig_o));
            check({tag, "_hold_rdy"}, 512'(in_ready), 512'(0));
            check({tag, "_hold_busy"}, 512'(busy), 512'(1));
            @(negedge clk);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        check({tag, "_dvalid_clr"}, 512'(digest_valid), 512'(0));
        check({tag, "_idle"}, 512'(busy), 512'(0));
        check({tag, "_starts"}, 512'(got_blk.size()), 512'(nblk));
        for (int i = 0; i < nblk && i < got_blk.size(); i++) begin
            check({tag, "_block"}, got_blk[i], exp_blk[i]);
            check({tag, "_first_run"}, 512'(got_fr[i]), 512'(i == 0));
        end
        check({tag, "_digest"}, 512'(dig_o), 512'(exp_dig));
    endtask

    initial begin
        logic [255:0] dig;
        logic [511:0] b1;
        int lens [5];
        int waitc;
        lens = '{63, 64, 119, 120, 128};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        digest_ready = 1'b0;
        stub = 1'b0;
        fixed_lat = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_dvalid", 512'(digest_valid), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_err", 512'(err), 512'(0));
        check("rst_start", 512'(core_start), 512'(0));
        check("rst_block", core_block, 512'(0));
        check("rst_digest", 512'(digest_out), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 512'(in_ready), 512'(1));

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 1'b0, 0, dig);
        check("abc_const", 512'(dig), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        msg.delete();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 4; j++) msg.push_back(8'(8'h61 + i + j));
        run_msg("m56", 1'b1, 2, dig);
        check("m56_const", 512'(dig), 512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));
        check("m56_nstart", 512'(got_blk.size()), 512'(2));

        msg.delete();
        repeat (55) msg.push_back(8'h61);
        run_msg("a55", 1'b0, 0, dig);
        check("a55_nstart", 512'(got_blk.size()), 512'(1));

        msg.delete();
        repeat (64) msg.push_back(8'h61);
        run_msg("a64", 1'b0, 20, dig);
        check("a64_nstart", 512'(got_blk.size()), 512'(2));
        b1 = (got_blk.size() > 1) ? got_blk[1] : '0;
        check("a64_b1_80", 512'(b1[511:504]), 512'(8'h80));
        check("a64_b1_len", 512'(b1[63:0]), 512'(64'h200));

        for (int r = 0; r < 5; r++) begin
            msg.delete();
            repeat (lens[r]) msg.push_back(8'($urandom));
            run_msg("edge_len", 1'b1, int'($urandom_range(0, 3)), dig);
        end
        for (int r = 0; r < 10; r++) begin
            msg.delete();
            repeat ($urandom_range(1, 140)) msg.push_back(8'($urandom));
            run_msg("rand_len", 1'b1, int'($urandom_range(0, 3)), dig);
        end

        // Reset while waiting on the core for the first block.
        fixed_lat = 40;
        msg.delete();
        repeat (64) msg.push_back(8'($urandom));
        got_blk.delete();
        got_fr.delete();
        send_msg(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("wrdy_busy", 512'(busy), 512'(1));
        check("wrdy_in_ready", 512'(in_ready), 512'(0));
        check("wrdy_nstart", 512'(got_blk.size()), 512'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 512'(busy), 512'(0));
        check("mid_rst_in_ready", 512'(in_ready), 512'(0));
        check("mid_rst_block", core_block, 512'(0));
        check("mid_rst_start", 512'(core_start), 512'(0));
        check("mid_rst_dvalid", 512'(digest_valid), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fixed_lat = 0;
        @(negedge clk);
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc2", 1'b0, 0, dig);
        check("abc2_const", 512'(dig), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        // Core never completes: timeout must fire after TIMEOUT+1 cycles in the wait state.
        stub = 1'b1;
        got_blk.delete();
        got_fr.delete();
        send_msg(1'b0, 1'b1);
        waitc = 0;
        while (!core_start && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        check("stub_start", 512'(core_start), 512'(1));
        repeat (TIMEOUT + 2) @(negedge clk);
        check("stub_err_early", 512'(err), 512'(0));
        @(negedge clk);
        check("stub_err", 512'(err), 512'(1));
        check("stub_idle", 512'(busy), 512'(0));
        check("stub_in_ready", 512'(in_ready), 512'(1));
        check("stub_dvalid", 512'(digest_valid), 512'(0));
        repeat (5) @(negedge clk);
        check("stub_err_sticky", 512'(err), 512'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stub = 1'b0;
        @(negedge clk);
        check("err_cleared", 512'(err), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
